vga_frame_sched: RTL and testbench

VGA_FRAME_SCHED -- requirements
Module: vga_frame_sched

---
 rtl/vga_pkg.sv | 22 ++
 rtl/vga_debounce.sv | 32 +++
 rtl/vga_frame_sched.sv | 155 +++++++++++++++
 tb/tb_vga_frame_sched.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// Shared VGA timing defaults (640x480@60, 25 MHz pixel clock) and scheduler state type.
package vga_pkg;

   localparam int DEF_H_ACTIVE        = 640;
   localparam int DEF_H_FP            = 16;
   localparam int DEF_H_SYNC          = 96;
   localparam int DEF_H_BP            = 48;
   localparam int DEF_V_ACTIVE        = 480;
   localparam int DEF_V_FP            = 10;
   localparam int DEF_V_SYNC          = 2;
   localparam int DEF_V_BP            = 33;
   localparam int DEF_DEBOUNCE_CYCLES = 250000;

   localparam int H_TOTAL = DEF_H_ACTIVE + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;
   localparam int V_TOTAL = DEF_V_ACTIVE + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;

   typedef enum logic {
      S_IDLE = 1'b0,
      S_REQ  = 1'b1
   } sched_state_t;

endpackage

// File: rtl/vga_debounce.sv
// Level debouncer: output follows the input only after CYCLES consecutive samples at the new level.
module vga_debounce
   import vga_pkg::*;
#(
   parameter int CYCLES = DEF_DEBOUNCE_CYCLES
)(
   input  logic clk,
   input  logic rst,
   input  logic din,
   output logic dout
);

   localparam int            CW   = $clog2(CYCLES + 1);
   localparam logic [CW-1:0] LAST = CW'(CYCLES - 1);

   logic [CW-1:0] cnt;

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt  <= '0;
         dout <= 1'b0;
      end else if (din == dout) begin
         cnt <= '0;
      end else if (cnt == LAST) begin
         cnt  <= '0;
         dout <= din;
      end else begin
         cnt <= cnt + CW'(1);
      end
   end

endmodule

// File: rtl/vga_frame_sched.sv
// VGA timing generator plus per-frame game-update request scheduler with button capture.
// Define VGA_DEBOUNCE_EN to insert vga_debounce after the button synchronizer.
module vga_frame_sched
   import vga_pkg::*;
#(
   parameter int H_ACTIVE        = DEF_H_ACTIVE,
   parameter int H_FP            = DEF_H_FP,
   parameter int H_SYNC          = DEF_H_SYNC,
   parameter int H_BP            = DEF_H_BP,
   parameter int V_ACTIVE        = DEF_V_ACTIVE,
   parameter int V_FP            = DEF_V_FP,
   parameter int V_SYNC          = DEF_V_SYNC,
   parameter int V_BP            = DEF_V_BP,
   parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
)(
   input  logic       CLK_25MHZ,
   input  logic       RESET,
   input  logic       BTN,
   output logic       VGA_HSYNC,
   output logic       VGA_VSYNC,
   output logic       VGA_DE,
   output logic [9:0] X,
   output logic [9:0] Y,
   output logic       FRAME_START,
   output logic       UPD_REQ,
   input  logic       UPD_ACK,
   output logic       UPD_BTN,
   output logic       UPD_OVERRUN
);

   localparam logic [9:0] H_LAST = 10'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
   localparam logic [9:0] V_LAST = 10'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
   localparam logic [9:0] H_VIS  = 10'(H_ACTIVE);
   localparam logic [9:0] V_VIS  = 10'(V_ACTIVE);
   localparam logic [9:0] HS_BEG = 10'(H_ACTIVE + H_FP);
   localparam logic [9:0] HS_END = 10'(H_ACTIVE + H_FP + H_SYNC - 1);
   localparam logic [9:0] VS_BEG = 10'(V_ACTIVE + V_FP);
   localparam logic [9:0] VS_END = 10'(V_ACTIVE + V_FP + V_SYNC - 1);

   // running is low for the first post-reset edge so position 0,0 is shown first
   logic       running;
   logic [9:0] h_nxt, v_nxt;

   always_comb begin
      h_nxt = '0;
      v_nxt = '0;
      if (running) begin
         if (X == H_LAST) begin
            h_nxt = '0;
            v_nxt = (Y == V_LAST) ? '0 : Y + 10'd1;
         end else begin
            h_nxt = X + 10'd1;
            v_nxt = Y;
         end
      end
   end

   always_ff @(posedge CLK_25MHZ) begin
      if (RESET) begin
         running     <= 1'b0;
         X           <= '0;
         Y           <= '0;
         VGA_DE      <= 1'b0;
         VGA_HSYNC   <= 1'b1;
         VGA_VSYNC   <= 1'b1;
         FRAME_START <= 1'b0;
      end else begin
         running     <= 1'b1;
         X           <= h_nxt;
         Y           <= v_nxt;
         VGA_DE      <= (h_nxt < H_VIS) && (v_nxt < V_VIS);
         VGA_HSYNC   <= !((h_nxt >= HS_BEG) && (h_nxt <= HS_END));
         VGA_VSYNC   <= !((v_nxt >= VS_BEG) && (v_nxt <= VS_END));
         FRAME_START <= (h_nxt == '0) && (v_nxt == '0);
      end
   end

   logic btn_s1, btn_s2, btn_c, btn_c_d, press;

   always_ff @(posedge CLK_25MHZ) begin
      if (RESET) begin
         btn_s1  <= 1'b0;
         btn_s2  <= 1'b0;
         btn_c_d <= 1'b0;
      end else begin
         btn_s1  <= BTN;
         btn_s2  <= btn_s1;
         btn_c_d <= btn_c;
      end
   end

`ifdef VGA_DEBOUNCE_EN
   vga_debounce #(.CYCLES(DEBOUNCE_CYCLES)) u_debounce (
      .clk  (CLK_25MHZ),
      .rst  (RESET),
      .din  (btn_s2),
      .dout (btn_c)
   );
`else
   assign btn_c = btn_s2;
`endif

   assign press = btn_c & ~btn_c_d;

   // On request entry the pending press moves into UPD_BTN; later presses start a fresh flag
   sched_state_t state, state_nxt;
   logic         pend, pend_nxt, upd_btn_nxt;
   logic         at_origin, at_req_line;

   assign at_origin   = running && (X == '0) && (Y == '0);
   assign at_req_line = running && (X == '0) && (Y == V_VIS);

   always_comb begin
      state_nxt   = state;
      pend_nxt    = pend | press;
      upd_btn_nxt = UPD_BTN;
      UPD_OVERRUN = 1'b0;
      case (state)
         S_IDLE: begin
            if (at_req_line) begin
               state_nxt   = S_REQ;
               upd_btn_nxt = pend;
               pend_nxt    = press;
            end
         end
         S_REQ: begin
            if (UPD_ACK) begin
               state_nxt   = S_IDLE;
               upd_btn_nxt = 1'b0;
            end else if (at_origin) begin
               state_nxt   = S_IDLE;
               upd_btn_nxt = 1'b0;
               pend_nxt    = pend | press | UPD_BTN;
               UPD_OVERRUN = 1'b1;
            end
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge CLK_25MHZ) begin
      if (RESET) begin
         state   <= S_IDLE;
         pend    <= 1'b0;
         UPD_BTN <= 1'b0;
      end else begin
         state   <= state_nxt;
         pend    <= pend_nxt;
         UPD_BTN <= upd_btn_nxt;
      end
   end

   assign UPD_REQ = (state == S_REQ);

endmodule

// File: tb/tb_vga_frame_sched.sv
// Self-checking bench for vga_frame_sched on a shrunken 25x17 raster; honours VGA_DEBOUNCE_EN.
module tb_vga_frame_sched;

   localparam int HA = 16, HF = 2, HSW = 4, HB = 3;
   localparam int VA = 10, VF = 2, VSW = 2, VB = 3;
   localparam int DEB = 8;
   localparam int HT = HA + HF + HSW + HB;
   localparam int VT = VA + VF + VSW + VB;
   localparam int FT = HT * VT;

   logic       CLK_25MHZ = 1'b0;
   logic       RESET = 1'b1, BTN = 1'b0, UPD_ACK = 1'b0;
   logic       VGA_HSYNC, VGA_VSYNC, VGA_DE, FRAME_START, UPD_REQ, UPD_BTN, UPD_OVERRUN;
   logic [9:0] X, Y;

   logic nxt_rst = 1'b1, nxt_btn = 1'b0, nxt_ack = 1'b0;
   int   n_tests = 0, n_fail = 0, n_prints = 0;

   vga_frame_sched #(
      .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HSW), .H_BP(HB),
      .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VSW), .V_BP(VB),
      .DEBOUNCE_CYCLES(DEB)
   ) dut (
      .CLK_25MHZ(CLK_25MHZ), .RESET(RESET), .BTN(BTN),
      .VGA_HSYNC(VGA_HSYNC), .VGA_VSYNC(VGA_VSYNC), .VGA_DE(VGA_DE),
      .X(X), .Y(Y), .FRAME_START(FRAME_START),
      .UPD_REQ(UPD_REQ), .UPD_ACK(UPD_ACK), .UPD_BTN(UPD_BTN), .UPD_OVERRUN(UPD_OVERRUN)
   );

   always #5 CLK_25MHZ = ~CLK_25MHZ;

   // Reference: raster position as a frame offset, button as a sample history, request as flags
   bit m_run, m_req, m_ubtn, m_pend;
   int m_pos;
   bit b1, c1, c2;
`ifdef VGA_DEBOUNCE_EN
   bit b2, d_out;
   int d_run;
`endif

   always @(posedge CLK_25MHZ) begin : model
      int mx, my;
      bit press, cond_now;
      if (RESET) begin
         m_run = 0; m_pos = 0; m_req = 0; m_ubtn = 0; m_pend = 0;
         b1 = 0; c1 = 0; c2 = 0;
`ifdef VGA_DEBOUNCE_EN
         b2 = 0; d_out = 0; d_run = 0;
`endif
      end else begin
         mx = m_pos % HT;
         my = m_pos / HT;
         press = c1 && !c2;
         if (m_req) begin
            if (UPD_ACK) begin
               m_req = 0; m_ubtn = 0; m_pend = m_pend | press;
            end else if (m_run && mx == 0 && my == 0) begin
               m_req = 0; m_pend = m_pend | m_ubtn | press; m_ubtn = 0;
            end else begin
               m_pend = m_pend | press;
            end
         end else if (m_run && mx == 0 && my == VA) begin
            m_req = 1; m_ubtn = m_pend; m_pend = press;
         end else begin
            m_pend = m_pend | press;
         end
`ifdef VGA_DEBOUNCE_EN
         if (b2 != d_out) begin
            d_run++;
            if (d_run == DEB) begin
               d_out = b2;
               d_run = 0;
            end
         end else begin
            d_run = 0;
         end
         cond_now = d_out;
         b2 = b1;
`else
         cond_now = b1;
`endif
         c2 = c1;
         c1 = cond_now;
         b1 = BTN;
         if (!m_run) begin
            m_run = 1;
            m_pos = 0;
         end else begin
            m_pos = (m_pos + 1) % FT;
         end
      end
   end

   task automatic chk(input string name, input int act, input int exp);
      n_tests++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic check_model();
      int ex, ey;
      logic [6:0] ef, af;
      ex = m_run ? m_pos % HT : 0;
      ey = m_run ? m_pos / HT : 0;
      ef = {m_run && ex < HA && ey < VA,
            !(m_run && ex >= HA + HF && ex < HA + HF + HSW),
            !(m_run && ey >= VA + VF && ey < VA + VF + VSW),
            m_run && m_pos == 0,
            m_req, m_ubtn,
            m_req && m_run && ex == 0 && ey == 0 && !UPD_ACK};
      af = {VGA_DE, VGA_HSYNC, VGA_VSYNC, FRAME_START, UPD_REQ, UPD_BTN, UPD_OVERRUN};
      n_tests++;
      if (int'(X) != ex || int'(Y) != ey || af != ef) begin
         n_fail++;
         if (n_prints < 20) begin
            n_prints++;
            $display("FAIL cycle_check t=%0t: X=%0d Y=%0d de/hs/vs/fs/req/btn/ovr=%b, expected X=%0d Y=%0d %b",
                     $time, X, Y, af, ex, ey, ef);
         end
      end
   endtask

   task automatic cyc();
      @(posedge CLK_25MHZ);
      #2;
      RESET   = nxt_rst;
      BTN     = nxt_btn;
      UPD_ACK = nxt_ack;
      @(negedge CLK_25MHZ);
      check_model();
   endtask

   task automatic wait_xy(input int x, input int y);
      for (int i = 0; i < 2 * FT; i++) begin
         cyc();
         if (int'(X) == x && int'(Y) == y) return;
      end
      n_tests++;
      n_fail++;
      $display("FAIL wait_xy: position (%0d,%0d) not reached within %0d cycles", x, y, 2 * FT);
   endtask

   task automatic ack_once();
      nxt_ack = 1'b1;
      cyc();
      nxt_ack = 1'b0;
      cyc();
   endtask

   task automatic press_for(input int n);
      nxt_btn = 1'b1;
      repeat (n) cyc();
      nxt_btn = 1'b0;
   endtask

   initial begin
      int hs_lo, vs_lo, de_hi, fs_n;

      // reset state
      repeat (3) cyc();
      chk("rst_x", X, 0);              chk("rst_y", Y, 0);
      chk("rst_hsync", VGA_HSYNC, 1);  chk("rst_vsync", VGA_VSYNC, 1);
      chk("rst_de", VGA_DE, 0);        chk("rst_fs", FRAME_START, 0);
      chk("rst_req", UPD_REQ, 0);      chk("rst_ovr", UPD_OVERRUN, 0);

      // first frame after release: raster statistics
      nxt_rst = 1'b0;
      cyc();
      cyc();
      chk("first_x", X, 0);  chk("first_y", Y, 0);
      chk("first_de", VGA_DE, 1);  chk("first_fs", FRAME_START, 1);
      hs_lo = 0; vs_lo = 0; de_hi = 0; fs_n = 0;
      for (int i = 0; i < FT; i++) begin
         if (i > 0) cyc();
         hs_lo += int'(!VGA_HSYNC);
         vs_lo += int'(!VGA_VSYNC);
         de_hi += int'(VGA_DE);
         fs_n  += int'(FRAME_START);
         if (i == 15) begin chk("x15", X, 15); chk("de_x15", VGA_DE, 1); end
         if (i == 16) begin chk("x16", X, 16); chk("de_x16", VGA_DE, 0); end
      end
      chk("hsync_low_per_frame", hs_lo, 68);   // 17 lines x 4
      chk("vsync_low_per_frame", vs_lo, 50);   // 2 lines x 25
      chk("de_high_per_frame", de_hi, 160);    // 16 x 10
      chk("fs_per_frame", fs_n, 1);
      cyc();
      chk("fs_period", FRAME_START, 1);
      chk("ovr_unacked", UPD_OVERRUN, 1);
      chk("ovr_req_still", UPD_REQ, 1);
      cyc();
      chk("ovr_pulse_end", UPD_OVERRUN, 0);
      chk("ovr_req_low", UPD_REQ, 0);

      // held button, acked request
      wait_xy(0, 3);
      nxt_btn = 1'b1;
      wait_xy(0, VA);
      chk("req_before_rise", UPD_REQ, 0);
      cyc();
      chk("req_rise_x", X, 1);
      chk("req_rise", UPD_REQ, 1);
      chk("req_btn", UPD_BTN, 1);
      repeat (4) cyc();
      nxt_ack = 1'b1;
      cyc();
      chk("req_during_ack", UPD_REQ, 1);
      nxt_ack = 1'b0;
      cyc();
      chk("req_after_ack", UPD_REQ, 0);
      wait_xy(1, VA);
      chk("held_next_req", UPD_REQ, 1);
      chk("held_next_btn", UPD_BTN, 0);
      nxt_btn = 1'b0;
      ack_once();

      // unacked request with a press during it
      wait_xy(0, 2);
      press_for(12);
      wait_xy(1, VA);
      chk("b_req_btn", UPD_BTN, 1);
      wait_xy(0, 12);
      press_for(12);
      wait_xy(0, 0);
      chk("b_overrun", UPD_OVERRUN, 1);
      cyc();
      chk("b_overrun_end", UPD_OVERRUN, 0);
      chk("b_req_low", UPD_REQ, 0);
      wait_xy(1, VA);
      chk("b_kept_btn", UPD_BTN, 1);
      ack_once();
      wait_xy(1, VA);
      chk("b_cleared_btn", UPD_BTN, 0);

      // acknowledge coincident with frame origin
      wait_xy(HT - 1, VT - 1);
      nxt_ack = 1'b1;
      cyc();
      chk("c_origin_x", X, 0);
      chk("c_no_overrun", UPD_OVERRUN, 0);
      nxt_ack = 1'b0;
      cyc();
      chk("c_req_dropped", UPD_REQ, 0);
      chk("c_no_overrun_after", UPD_OVERRUN, 0);

      // reset in the middle of a request
      wait_xy(3, VA);
      chk("d_req_active", UPD_REQ, 1);
      nxt_rst = 1'b1;
      cyc();
      cyc();
      chk("d_req_abandoned", UPD_REQ, 0);
      chk("d_no_overrun", UPD_OVERRUN, 0);
      nxt_rst = 1'b0;
      cyc();
      cyc();
      chk("d_restart_fs", FRAME_START, 1);
      chk("d_restart_de", VGA_DE, 1);

`ifdef VGA_DEBOUNCE_EN
      // short glitch filtered, long hold accepted
      wait_xy(0, 3);
      press_for(5);
      wait_xy(1, VA);
      chk("deb_glitch_btn", UPD_BTN, 0);
      ack_once();
      wait_xy(0, 3);
      press_for(10);
      wait_xy(1, VA);
      chk("deb_hold_btn", UPD_BTN, 1);
      ack_once();
`endif

      // randomized traffic
      begin
         int hold, ack_pct;
         hold = 0;
         ack_pct = 4;
         for (int n = 0; n < 6000; n++) begin
            if (hold == 0) begin
               nxt_btn = 1'($urandom_range(0, 1));
               hold = $urandom_range(1, 20);
            end else begin
               hold--;
            end
            nxt_ack = ($urandom_range(0, 99) < ack_pct);
            nxt_rst = ($urandom_range(0, 2999) == 0);
            cyc();
            if (FRAME_START) ack_pct = ($urandom_range(0, 3) == 0) ? 0 : 4;
         end
      end
      nxt_rst = 1'b0;
      nxt_ack = 1'b0;
      nxt_btn = 1'b0;
      repeat (5) cyc();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
